// File: rtl/bg_scroll_ctrl.sv
// Purpose : frame-synchronous background scroll controller (idle/run/halt game phase FSM),
//           per-frame scroll offset and speed schedule, climb distance, texture address.
// Latency : pixel_addr is registered, 1 cycle after vcount_in/hcount_in; state updates on a frame tick
//           take effect at the edge ending the tick cycle.
// Backpressure: none; free-running, every input is sampled every cycle.
//
// Ports:
//   pclk_in           pixel clock
//   rst_in            synchronous active-high reset
//   vcount_in[10:0]   vertical pixel counter
//   hcount_in[10:0]   horizontal pixel counter
//   vblnk_in          vertical blanking; its rising edge is the frame tick
//   start_in          pulse: IDLE->RUN, HALT->IDLE
//   stop_in           pulse: RUN->HALT
//   boost_in          (BG_SCROLL_BOOST_EN only) doubles the advance on a RUN tick
//   pixel_addr[11:0]  {tile row, tile column} texture address
//   scroll_y[5:0]     vertical offset, wraps mod 64
//   speed[2:0]        speed level, pixels/frame
//   distance[15:0]    pixels climbed, saturating
//   running           high in RUN
//
// Optional feature macro: BG_SCROLL_BOOST_EN

module bg_scroll_ctrl #(
   parameter int FRAMES_PER_LEVEL = 600,
   parameter int MAX_SPEED        = 4
) (
   input  logic        pclk_in,
   input  logic        rst_in,
   input  logic [10:0] vcount_in,
   input  logic [10:0] hcount_in,
   input  logic        vblnk_in,
   input  logic        start_in,
   input  logic        stop_in,
`ifdef BG_SCROLL_BOOST_EN
   input  logic        boost_in,
`endif
   output logic [11:0] pixel_addr,
   output logic [5:0]  scroll_y,
   output logic [2:0]  speed,
   output logic [15:0] distance,
   output logic        running
);

   localparam logic [15:0] FPL_LAST = 16'(FRAMES_PER_LEVEL - 1);
   localparam logic [2:0]  MAX_SPD  = 3'(MAX_SPEED);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state;
   logic        vblnk_d;
   logic [15:0] frame_cnt;

   logic        tick;
   logic [3:0]  adv;
   logic [5:0]  scroll_next;
   logic [16:0] dist_sum;
   logic [5:0]  row_dat;
   logic        unused_bits;

   // Only the low 6 bits of the counters address a 64x64 tile.
   assign unused_bits = ^{vcount_in[10:6], hcount_in[10:6]};

   // A tick in the first post-reset cycle (vblnk_in already high) is harmless:
   // the FSM is in IDLE, where ticks never change state.
   assign tick = vblnk_in & ~vblnk_d;

   always_comb begin
      adv = {1'b0, speed};
`ifdef BG_SCROLL_BOOST_EN
      if (boost_in) begin
         adv = {speed, 1'b0};
      end
`endif
   end

   assign scroll_next = scroll_y + {2'b00, adv};
   assign dist_sum    = {1'b0, distance} + {13'd0, adv};
   // Row moves opposite to the climb so the texture slides downward.
   assign row_dat     = vcount_in[5:0] - scroll_y;

   always_ff @(posedge pclk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         vblnk_d    <= 1'b0;
         frame_cnt  <= 16'd0;
         pixel_addr <= 12'd0;
         scroll_y   <= 6'd0;
         speed      <= 3'd0;
         distance   <= 16'd0;
         running    <= 1'b0;
      end else begin
         vblnk_d    <= vblnk_in;
         pixel_addr <= {row_dat, hcount_in[5:0]};

         case (state)
            IDLE: begin
               // A coincident tick is swallowed: the transition itself is the only effect.
               if (start_in) begin
                  state     <= RUN;
                  running   <= 1'b1;
                  speed     <= 3'd1;
                  frame_cnt <= 16'd0;
               end
            end

            RUN: begin
               // stop has priority over both start and a coincident tick.
               if (stop_in) begin
                  state   <= HALT;
                  running <= 1'b0;
               end else if (tick) begin
                  scroll_y <= scroll_next;
                  distance <= dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
                  if (frame_cnt == FPL_LAST) begin
                     frame_cnt <= 16'd0;
                     if (speed < MAX_SPD) begin
                        speed <= speed + 3'd1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 16'd1;
                  end
               end
            end

            HALT: begin
               if (start_in) begin
                  state     <= IDLE;
                  running   <= 1'b0;
                  scroll_y  <= 6'd0;
                  distance  <= 16'd0;
                  speed     <= 3'd0;
                  frame_cnt <= 16'd0;
               end
            end

            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed testbench for bg_scroll_ctrl (FRAMES_PER_LEVEL=3, MAX_SPEED=3).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.

module tb_bg_scroll_ctrl;

   logic        clk;
   logic        rst;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vblnk;
   logic        start;
   logic        stop;
`ifdef BG_SCROLL_BOOST_EN
   logic        boost;
`endif
   logic [11:0] pixel_addr;
   logic [5:0]  scroll_y;
   logic [2:0]  speed;
   logic [15:0] distance;
   logic        running;

   int checks = 0;
   int errors = 0;

   bg_scroll_ctrl #(
      .FRAMES_PER_LEVEL(3),
      .MAX_SPEED(3)
   ) dut (
      .pclk_in   (clk),
      .rst_in    (rst),
      .vcount_in (vcount),
      .hcount_in (hcount),
      .vblnk_in  (vblnk),
      .start_in  (start),
      .stop_in   (stop),
`ifdef BG_SCROLL_BOOST_EN
      .boost_in  (boost),
`endif
      .pixel_addr(pixel_addr),
      .scroll_y  (scroll_y),
      .speed     (speed),
      .distance  (distance),
      .running   (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      vblnk = 1'b1;
      cyc();
      vblnk = 1'b0;
      cyc();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] spd_seq [7];
      logic [5:0] boost_exp;
      spd_seq = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};

      rst    = 1'b1;
      vcount = 11'd0;
      hcount = 11'd0;
      vblnk  = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
`ifdef BG_SCROLL_BOOST_EN
      boost  = 1'b0;
`endif

      // Reset with blanking high
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_pixel_addr", 32'(pixel_addr), 32'h0);
      chk("rst_scroll_y",   32'(scroll_y),   32'h0);
      chk("rst_speed",      32'(speed),      32'h0);
      chk("rst_distance",   32'(distance),   32'h0);
      chk("rst_running",    32'(running),    32'h0);
      vblnk = 1'b0;
      cyc();

      // Address path in IDLE: row 70%64=6, column 130%64=2
      vcount = 11'd70;
      hcount = 11'd130;
      cyc();
      chk("idle_addr", 32'(pixel_addr), 32'h182);

      // Ticks and stop are ignored in IDLE
      tick();
      chk("idle_tick_scroll", 32'(scroll_y), 32'h0);
      chk("idle_tick_speed",  32'(speed),    32'h0);
      pulse_stop();
      chk("idle_stop_running", 32'(running), 32'h0);

      // Start and level schedule
      pulse_start();
      chk("start_running", 32'(running), 32'h1);
      chk("start_speed",   32'(speed),   32'h1);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("level_speed_%0d", i), 32'(speed), 32'(spd_seq[i]));
         tick();
      end
      chk("seven_distance", 32'(distance), 32'd12);
      chk("seven_scroll",   32'(scroll_y), 32'd12);

      // Saturated at speed 3: 38 more ticks land scroll at 62, one more wraps to 1
      for (int i = 0; i < 38; i++) tick();
      chk("pre_wrap_scroll", 32'(scroll_y), 32'd62);
      tick();
      chk("wrap_scroll",   32'(scroll_y), 32'd1);
      chk("sat_speed",     32'(speed),    32'd3);
      chk("wrap_distance", 32'(distance), 32'd129);

      // Row field 0-1 = 63, column 5
      vcount = 11'd0;
      hcount = 11'd5;
      cyc();
      chk("wrap_addr", 32'(pixel_addr), 32'hFC5);

      // start in RUN ignored
      pulse_start();
      chk("run_start_running", 32'(running), 32'h1);
      chk("run_start_speed",   32'(speed),   32'h3);

      // stop coincident with tick: no advance
      stop  = 1'b1;
      vblnk = 1'b1;
      cyc();
      stop  = 1'b0;
      vblnk = 1'b0;
      cyc();
      chk("stop_tick_scroll",   32'(scroll_y), 32'd1);
      chk("stop_tick_distance", 32'(distance), 32'd129);
      chk("stop_tick_running",  32'(running),  32'h0);
      tick();
      chk("halt_tick_scroll", 32'(scroll_y), 32'd1);
      pulse_stop();
      chk("halt_stop_running", 32'(running), 32'h0);

      // start in HALT -> IDLE, everything cleared
      pulse_start();
      chk("restart_scroll",   32'(scroll_y), 32'd0);
      chk("restart_distance", 32'(distance), 32'd0);
      chk("restart_speed",    32'(speed),    32'd0);
      chk("restart_running",  32'(running),  32'h0);

      // start+stop together in IDLE: start wins
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      chk("both_idle_running", 32'(running), 32'h1);
      chk("both_idle_speed",   32'(speed),   32'h1);

      // Back to IDLE, then start coincident with a tick: no advance
      pulse_stop();
      pulse_start();
      start = 1'b1;
      vblnk = 1'b1;
      cyc();
      start = 1'b0;
      vblnk = 1'b0;
      cyc();
      chk("start_tick_running", 32'(running), 32'h1);
      chk("start_tick_scroll",  32'(scroll_y), 32'd0);
      chk("start_tick_dist",    32'(distance), 32'd0);

      // Reach speed 2, then one tick with boost requested
      for (int i = 0; i < 3; i++) tick();
      chk("pre_boost_scroll", 32'(scroll_y), 32'd3);
      chk("pre_boost_speed",  32'(speed),    32'd2);
`ifdef BG_SCROLL_BOOST_EN
      boost     = 1'b1;
      boost_exp = 6'd7;
`else
      boost_exp = 6'd5;
`endif
      tick();
`ifdef BG_SCROLL_BOOST_EN
      boost = 1'b0;
`endif
      chk("boost_scroll", 32'(scroll_y), 32'(boost_exp));
      chk("boost_speed",  32'(speed),    32'd2);

      // Reset mid-RUN
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_scroll",   32'(scroll_y), 32'd0);
      chk("mid_rst_distance", 32'(distance), 32'd0);
      chk("mid_rst_speed",    32'(speed),    32'd0);
      chk("mid_rst_running",  32'(running),  32'h0);

      // Distance saturation: total after N ticks = 9 + 3*(N-6)
      pulse_start();
      for (int i = 0; i < 21847; i++) tick();
      chk("near_sat_distance", 32'(distance), 32'hFFFC);
      chk("near_sat_scroll",   32'(scroll_y), 32'd60);
      tick();
      chk("sat_distance",      32'(distance), 32'hFFFF);
      chk("sat_scroll",        32'(scroll_y), 32'd63);
      tick();
      chk("hold_sat_distance", 32'(distance), 32'hFFFF);
      chk("hold_sat_scroll",   32'(scroll_y), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
